mr_ex_pipe: RTL
===============

// Module: mr_ex_pipe
// PURPOSE
//  Parametrised, elastic MR->EX pipeline stage for the CNN co-processor. Registers the image
//  window and filter taps read in MR, plus the write-enable and writeback sideband (result
//  select, destination address), toward the EX MAC array.
//  Adds a valid/ready handshake, stall, synchronous flush, a configurable sideband delay
//  (aligns writeback info with EX latency) and an optional skid buffer.
// PARAMETERS
//  N       8   data width per pixel/tap
//  IWORDS  10  image words per transfer (i_data width = IWORDS*N)
//  FWORDS  9   filter taps per transfer (f_data width = FWORDS*N)
//  RW      2   result-select width
//  DW      10  destination address width
//  SB_DLY  1   extra sideband stages after the data stage, legal range 0..4
// PORTS
//  clock      in   1          rising-edge clock
//  reset      in   1          synchronous, active-low reset
//  flush      in   1          synchronous pipeline kill (branch/abort from RISC-V core)
//  in_valid   in   1          MR payload valid
//  in_ready   out  1          stage accepts payload
//  i_data     in   IWORDS*N   image window
//  f_data     in   FWORDS*N   filter taps
//  w_en       in   1          memory write enable
//  r_sel      in   RW         result select
//  dest       in   DW         writeback address
//  out_valid  out  1          EX payload valid
//  out_ready  in   1          EX accepts payload / EX pipeline advances
//  iout       out  IWORDS*N   registered image window
//  fout       out  FWORDS*N   registered filter taps
//  wen_out    out  1          registered w_en, qualified by out_valid
//  sb_valid   out  1          delayed sideband valid
//  rout       out  RW         delayed r_sel
//  dest_out   out  DW         delayed dest
// BEHAVIOUR
//  - Reset (reset==0 at posedge): every output and internal register = 0, in_ready = 0; in_ready
//    may assert from the first cycle after reset is released.
//  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
//  - Data stage: on in_fire, iout/fout/wen_out/r_sel/dest are captured and out_valid = 1 the next
//    cycle (latency 1). out_valid & payload hold stable while out_ready = 0. A simultaneous
//    out_fire & in_fire replaces the payload with no bubble (full throughput, 1 transfer/cycle).
//  - wen_out = 0 whenever out_valid = 0.
//  - Sideband line: SB_DLY stages {v, r, d}; shifts only on cycles with out_ready = 1. Stage 0
//    loads {out_fire, r_sel_q, dest_q}. SB_DLY = 0 means sb_valid = out_valid and rout/dest_out
//    come straight from the data stage. When out_ready = 0 the line holds (EX stalled).
//  - Width rules: pure pass-through, no arithmetic, no truncation.
//  - Flush: at the clock edge all valid bits (out_valid, skid, every sb stage) are cleared;
//    in_ready = 0 during the flush cycle; an in_valid beat in that cycle is dropped.
//    Flush beats out_fire/in_fire in the same cycle. Payload registers need not be cleared.
//  - reset has priority over flush; reset mid-transfer discards all in-flight beats.
// CONFIGURATION
//  MR_EX_SKID_EN defined: 1-entry skid register. in_ready is a registered signal (= !skid_full),
//    with no combinational path from out_ready. A beat accepted while the main stage is stalled
//    goes to skid; skid drains into the main stage on the next out_fire, preserving order.
//    Throughput is still 1/cycle.
//  MR_EX_SKID_EN undefined: no skid; in_ready = out_ready | !out_valid, combinational.
// STRUCTURE
//  - Shared package cnn_pkg: N, IWORDS, FWORDS, RW, DW defaults and the typedef sb_t {v, r, d}.
//  - One sub-module, mr_ex_sb_delay (parametrised SB_DLY shift line with enable and clear),
//    instantiated once; all other logic is flat.
// TESTING
//  1 Reset: hold reset=0 for 3 cycles with in_valid=1 -> every output is 0 and in_ready=0. The
//    cycle after release -> in_ready=1.
//  2 Streaming: SB_DLY=1, out_ready=1, 4 beats with dest=1,2,3,4 back-to-back -> out_valid on
//    cycles 1..4 with iout in order; dest_out=1..4 on cycles 2..5 with sb_valid=1.
//  3 Stall: out_ready=0 for 3 cycles with a beat held -> iout/fout stable and the sb line frozen.
//    Without the macro, in_ready=0. With the macro, one extra beat is accepted, then in_ready=0.
//    No beat is lost.
//  4 Flush: assert flush while out_valid=1, sb stage valid and in_valid=1 -> next cycle
//    out_valid=0 and sb_valid=0; the incoming beat never appears.
//  5 Sideband depth: SB_DLY=0 and SB_DLY=4, single beat with r_sel=2'b10, dest=10'h3FF ->
//    rout/dest_out appear with out_valid (depth 0) or 4 advancing cycles later (depth 4).
//  6 Random valid/ready against a scoreboard, 10k beats, with and without MR_EX_SKID_EN ->
//    in-order, lossless transfers, no duplicates; wen_out is never 1 while out_valid=0.

Source files
------------

// File: rtl/cnn_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package     : cnn_pkg                                                      |
// | Description : Shared defaults for the CNN co-processor MR->EX stage:       |
// |               pixel/tap width, words per transfer, writeback sideband      |
// |               widths, and the sideband record {v, r, d}.                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package cnn_pkg;

  localparam int C_N      = 8;   // bits per pixel / filter tap
  localparam int C_IWORDS = 10;  // image words per transfer
  localparam int C_FWORDS = 9;   // filter taps per transfer
  localparam int C_RW     = 2;   // result-select width
  localparam int C_DW     = 10;  // destination address width

  // Writeback sideband record at the default widths.
  typedef struct packed {
    logic            v;
    logic [C_RW-1:0] r;
    logic [C_DW-1:0] d;
  } sb_t;

endpackage : cnn_pkg
`default_nettype wire

// File: rtl/mr_ex_sb_delay.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mr_ex_sb_delay                                               |
// | Description : DEPTH-stage shift line for the writeback sideband. Shifts    |
// |               only when en=1, clr empties every stage, DEPTH=0 is a wire.  |
// | Ports       : clock  in  1  rising-edge clock                              |
// |               reset  in  1  synchronous active-low reset                   |
// |               en     in  1  advance the line one stage                     |
// |               clr    in  1  synchronous clear of all stages                |
// |               din    in  W  stage-0 load value                             |
// |               dout   out W  last stage (or din when DEPTH=0)               |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mr_ex_sb_delay #(
  parameter int W     = 1,
  parameter int DEPTH = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      assign dout = din;

      // Control inputs have no function when the line has no storage.
      logic unused_ctrl;
      assign unused_ctrl = &{1'b0, clock, reset, en, clr};
    end else begin : g_line
      logic [W-1:0] stage_q [DEPTH];

      always_ff @(posedge clock) begin
        if (!reset) begin
          for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
        end else if (clr) begin
          for (int k = 0; k < DEPTH; k++) stage_q[k] <= '0;
        end else if (en) begin
          stage_q[0] <= din;
          for (int k = 1; k < DEPTH; k++) stage_q[k] <= stage_q[k-1];
        end
      end

      assign dout = stage_q[DEPTH-1];
    end
  endgenerate

endmodule : mr_ex_sb_delay
`default_nettype wire

// File: rtl/mr_ex_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mr_ex_pipe                                                   |
// | Description : Elastic MR->EX pipeline register for the CNN MAC array.      |
// |               Valid/ready handshake, stall, synchronous flush, SB_DLY-deep |
// |               writeback sideband line, optional 1-entry skid buffer.       |
// | Macro       : MR_EX_SKID_EN - when defined, in_ready is registered         |
// |               (= !skid_full) and a stalled beat is parked in a skid slot.  |
// | Ports       : clock, reset (sync, active-low), flush                       |
// |               in_valid/in_ready, i_data, f_data, w_en, r_sel, dest (MR)    |
// |               out_valid/out_ready, iout, fout, wen_out (EX data)           |
// |               sb_valid, rout, dest_out (delayed writeback sideband)        |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mr_ex_pipe
  import cnn_pkg::*;
#(
  parameter int N      = C_N,
  parameter int IWORDS = C_IWORDS,
  parameter int FWORDS = C_FWORDS,
  parameter int RW     = C_RW,
  parameter int DW     = C_DW,
  parameter int SB_DLY = 1          // legal range 0..4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [IWORDS*N-1:0] i_data,
  input  logic [FWORDS*N-1:0] f_data,
  input  logic                w_en,
  input  logic [RW-1:0]       r_sel,
  input  logic [DW-1:0]       dest,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [IWORDS*N-1:0] iout,
  output logic [FWORDS*N-1:0] fout,
  output logic                wen_out,
  output logic                sb_valid,
  output logic [RW-1:0]       rout,
  output logic [DW-1:0]       dest_out
);

  localparam int IW  = IWORDS * N;
  localparam int FW  = FWORDS * N;
  localparam int SBW = 1 + RW + DW;

  typedef struct packed {
    logic [IW-1:0] img;
    logic [FW-1:0] flt;
    logic          wen;
    logic [RW-1:0] rsel;
    logic [DW-1:0] dst;
  } beat_t;

  beat_t in_beat;
  beat_t main_q, main_d;
  logic  out_valid_q, out_valid_d;
  logic  in_fire, out_fire;

  assign in_beat  = {i_data, f_data, w_en, r_sel, dest};
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid_q & out_ready;

`ifdef MR_EX_SKID_EN
  // ---------------------------------------------------------------------------
  // Skid variant: in_ready comes from a flop, so out_ready never reaches MR
  // combinationally. A beat accepted while the main stage is stalled waits in
  // the skid slot and is promoted ahead of any newer beat.
  // ---------------------------------------------------------------------------
  beat_t skid_q, skid_d;
  logic  skid_full_q, skid_full_d;

  // reset/flush gating keeps in_ready low during reset and the flush cycle.
  assign in_ready = reset & ~flush & ~skid_full_q;

  always_comb begin
    main_d      = main_q;
    out_valid_d = out_valid_q;
    skid_d      = skid_q;
    skid_full_d = skid_full_q;
    if (flush) begin
      out_valid_d = 1'b0;
      skid_full_d = 1'b0;
    end else if (out_fire || !out_valid_q) begin
      // Main slot frees up this cycle. in_ready is low whenever the skid is
      // full, so a skid promotion never coincides with a new acceptance.
      if (skid_full_q) begin
        main_d      = skid_q;
        out_valid_d = 1'b1;
        skid_full_d = 1'b0;
      end else if (in_fire) begin
        main_d      = in_beat;
        out_valid_d = 1'b1;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (in_fire) begin
      skid_d      = in_beat;
      skid_full_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      main_q      <= '0;
      skid_full_q <= 1'b0;
      skid_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      main_q      <= main_d;
      skid_full_q <= skid_full_d;
      skid_q      <= skid_d;
    end
  end
`else
  // ---------------------------------------------------------------------------
  // Plain variant: accept whenever the slot is empty or being drained.
  // ---------------------------------------------------------------------------
  assign in_ready = reset & ~flush & (out_ready | ~out_valid_q);

  always_comb begin
    main_d      = main_q;
    out_valid_d = out_valid_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (in_fire) begin
      main_d      = in_beat;
      out_valid_d = 1'b1;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      out_valid_q <= 1'b0;
      main_q      <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      main_q      <= main_d;
    end
  end
`endif

  assign out_valid = out_valid_q;
  assign iout      = main_q.img;
  assign fout      = main_q.flt;
  assign wen_out   = main_q.wen & out_valid_q;

  // ---------------------------------------------------------------------------
  // Writeback sideband. With a real line, stage 0 records whether a beat left
  // toward EX; with no line the sideband simply mirrors the data stage.
  // ---------------------------------------------------------------------------
  logic           sb_v_in;
  logic [SBW-1:0] sb_in;
  logic [SBW-1:0] sb_out;

  assign sb_v_in = (SB_DLY == 0) ? out_valid_q : out_fire;
  assign sb_in   = {sb_v_in, main_q.rsel, main_q.dst};

  mr_ex_sb_delay #(
    .W     (SBW),
    .DEPTH (SB_DLY)
  ) u_sb_delay (
    .clock (clock),
    .reset (reset),
    .en    (out_ready),
    .clr   (flush),
    .din   (sb_in),
    .dout  (sb_out)
  );

  assign sb_valid = sb_out[SBW-1];
  assign rout     = sb_out[SBW-2 -: RW];
  assign dest_out = sb_out[DW-1:0];

endmodule : mr_ex_pipe
`default_nettype wire
